// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and the round-robin helper for the edge event arbiter.
package edge_arb_pkg;

  typedef enum logic {EV_FALL = 1'b0, EV_RISE = 1'b1} edge_kind_t;

  localparam int MAX_CH = 16;
  localparam int RR_W   = $clog2(2 * MAX_CH);

  typedef struct packed {
    logic            found;
    logic [RR_W-1:0] idx;
  } rr_pick_t;

  // Unused request bits above 2*N_CH must be zero, so a 32-entry wrap equals a 2*N_CH wrap.
  function automatic rr_pick_t rr_pick(input logic [2*MAX_CH-1:0] req,
                                       input logic [RR_W-1:0]     ptr);
    rr_pick_t        res;
    logic [RR_W-1:0] idx_v;
    logic            hit_v;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < 2 * MAX_CH; k++) begin
      idx_v     = ptr + RR_W'(k);
      hit_v     = req[idx_v] & ~res.found;
      res.idx   = hit_v ? idx_v : res.idx;
      res.found = res.found | hit_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_det_ch.sv
// Per-channel edge detector; EDGE_ARB_SYNC_EN adds a 2-flop input synchronizer.
module edge_det_ch (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise_det,
  output logic fall_det
);

  logic lvl_s;
  logic a_ff_r;

`ifdef EDGE_ARB_SYNC_EN
  logic [1:0] sync_r;

  // Two-flop synchronizer for inputs from another clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], sig_in};
    end
  end

  assign lvl_s = sync_r[1];
`else
  assign lvl_s = sig_in;
`endif

  // Previous-cycle level; resets low so a line held high yields one rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_ff_r <= 1'b0;
    end else begin
      a_ff_r <= lvl_s;
    end
  end

  assign rise_det = ~a_ff_r & lvl_s;
  assign fall_det = a_ff_r & ~lvl_s;

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin scheduler of rise/fall events from N_CH lines onto one valid/ready slot.
// Define EDGE_ARB_SYNC_EN to synchronize asynchronous sig_in lines.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sig_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr
);

  localparam int N_REQ = 2 * N_CH;

  logic [N_CH-1:0]     rise_det_s;
  logic [N_CH-1:0]     fall_det_s;
  logic [N_CH-1:0]     ovf_set_s;
  logic [N_CH-1:0]     ovf_r;
  logic [N_REQ-1:0]    det_s;
  logic [N_REQ-1:0]    pend_r;
  logic [N_REQ-1:0]    gnt_s;
  logic [2*MAX_CH-1:0] req_s;
  rr_pick_t            pick_s;
  logic                slot_free_s;
  logic                grant_s;
  logic [RR_W-1:0]     rr_ptr_r;
  logic                evt_valid_r;
  logic [CH_W-1:0]     evt_ch_r;
  edge_kind_t          evt_kind_r;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_ch u_det (
      .clk      (clk),
      .reset    (reset),
      .sig_in   (sig_in[i]),
      .rise_det (rise_det_s[i]),
      .fall_det (fall_det_s[i])
    );

    assign det_s[2*i]   = rise_det_s[i];
    assign det_s[2*i+1] = fall_det_s[i];
    // A detection landing on a granted bit is a fresh event, not an overflow
    assign ovf_set_s[i] = (det_s[2*i]   & pend_r[2*i]   & ~gnt_s[2*i]) |
                          (det_s[2*i+1] & pend_r[2*i+1] & ~gnt_s[2*i+1]);
  end

  // Grant selection whenever the output slot is free
  always_comb begin
    req_s              = '0;
    req_s[N_REQ-1:0]   = pend_r;
    slot_free_s        = ~evt_valid_r | evt_ready;
    pick_s             = rr_pick(req_s, rr_ptr_r);
    grant_s            = slot_free_s & pick_s.found;
    for (int j = 0; j < N_REQ; j++) begin
      gnt_s[j] = grant_s & (pick_s.idx == RR_W'(j));
    end
  end

  // Pending bits, sticky overflow, round-robin pointer and output slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r      <= '0;
      ovf_r       <= '0;
      rr_ptr_r    <= '0;
      evt_valid_r <= 1'b0;
      evt_ch_r    <= '0;
      evt_kind_r  <= EV_FALL;
    end else begin
      pend_r <= (pend_r & ~gnt_s) | det_s;
      ovf_r  <= (ovf_r & ~ovf_clr) | ovf_set_s;
      if (grant_s) begin
        evt_valid_r <= 1'b1;
        evt_ch_r    <= CH_W'(pick_s.idx >> 1);
        evt_kind_r  <= pick_s.idx[0] ? EV_FALL : EV_RISE;
        rr_ptr_r    <= (pick_s.idx == RR_W'(N_REQ - 1)) ? '0 : pick_s.idx + RR_W'(1);
      end else if (evt_ready) begin
        evt_valid_r <= 1'b0;
      end else begin
        evt_valid_r <= evt_valid_r;
      end
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_ch    = evt_ch_r;
  assign evt_rise  = (evt_kind_r == EV_RISE);
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against a behavioural model.
module tb_edge_event_arbiter;

  localparam int N  = 4;
  localparam int NR = 2 * N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         evt_ready = 1'b1;
  logic         evt_valid;
  logic         evt_rise;
  logic [1:0]   evt_ch;
  logic [N-1:0] sig_in = '0;
  logic [N-1:0] ovf;
  logic [N-1:0] ovf_clr = '0;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit m_valid;
  bit m_rise;
  int m_ch;
  int m_ptr;
  bit m_pr[N];
  bit m_pf[N];
  bit m_prev[N];
  bit m_ovf[N];
  int cnt_rise[N];
  int cnt_fall[N];

  always #5 clk = ~clk;

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_rise = 1'b0; m_ch = 0; m_ptr = 0;
    for (int c = 0; c < N; c++) begin
      m_pr[c] = 1'b0; m_pf[c] = 1'b0; m_prev[c] = 1'b0; m_ovf[c] = 1'b0;
    end
  endtask

  function automatic bit pend(input int idx);
    return (idx % 2 == 0) ? m_pr[idx / 2] : m_pf[idx / 2];
  endfunction

  function automatic logic [N-1:0] ovf_vec();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_ovf[c];
    return v;
  endfunction

  // one clock edge of the model, using inputs as seen at that edge
  task automatic model_edge();
    int g;
    int idx;
    bit free_v, r, f, set_v;
    if (reset) begin
      model_reset();
    end else begin
      free_v = !m_valid || evt_ready;
      g = -1;
      if (free_v) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (g < 0 && pend(idx)) g = idx;
        end
      end
      for (int c = 0; c < N; c++) begin
        r = !m_prev[c] && sig_in[c];
        f = m_prev[c] && !sig_in[c];
        set_v = (r && m_pr[c] && g != 2 * c) || (f && m_pf[c] && g != 2 * c + 1);
        if (set_v) m_ovf[c] = 1'b1;
        else if (ovf_clr[c]) m_ovf[c] = 1'b0;
      end
      if (g >= 0) begin
        if (g % 2 == 0) m_pr[g / 2] = 1'b0;
        else m_pf[g / 2] = 1'b0;
      end
      for (int c = 0; c < N; c++) begin
        if (!m_prev[c] && sig_in[c]) m_pr[c] = 1'b1;
        if (m_prev[c] && !sig_in[c]) m_pf[c] = 1'b1;
        m_prev[c] = sig_in[c];
      end
      if (g >= 0) begin
        m_valid = 1'b1; m_ch = g / 2; m_rise = (g % 2 == 0); m_ptr = (g + 1) % NR;
      end else if (evt_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < N; c++) begin cnt_rise[c] = 0; cnt_fall[c] = 0; end
  endtask

  task automatic step();
    if (evt_valid && evt_ready && !reset) begin
      if (evt_rise) cnt_rise[evt_ch]++;
      else cnt_fall[evt_ch]++;
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", evt_valid, m_valid);
    if (m_valid) begin
      chk("ch", evt_ch, m_ch);
      chk("rise", evt_rise, m_rise);
    end
    chk("ovf", ovf, ovf_vec());
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    reset = 1'b1;
    sig_in = v;
    #1;
    model_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_ch", evt_ch, 0);
    chk("rst_rise", evt_rise, 0);
    chk("rst_ovf", ovf, 0);
    step();
    step();
    chk("rst_valid_hold", evt_valid, 0);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    clr_cnt();

    // input held high through reset release yields one ch3 rise
    evt_ready = 1'b1;
    do_reset(4'b1000);
    step(); chk("rel_lat1", evt_valid, 0);
    step(); chk("rel_valid", evt_valid, 1); chk("rel_ch", evt_ch, 3); chk("rel_rise", evt_rise, 1);
    step(); chk("rel_done", evt_valid, 0);

    // fairness from rr_ptr=0
    do_reset(4'b0000);
    sig_in = 4'b1011;
    step(); chk("fair_lat", evt_valid, 0);
    step(); chk("fair_v0", evt_valid, 1); chk("fair_c0", evt_ch, 0);
    step(); chk("fair_v1", evt_valid, 1); chk("fair_c1", evt_ch, 1);
    step(); chk("fair_v3", evt_valid, 1); chk("fair_c3", evt_ch, 3);
    step(); chk("fair_end", evt_valid, 0);

    // single ch2 rise, two-cycle latency, one-cycle event
    sig_in = 4'b1111;
    step(); chk("one_lat", evt_valid, 0);
    step(); chk("one_v", evt_valid, 1); chk("one_c", evt_ch, 2); chk("one_r", evt_rise, 1);
    step(); chk("one_end", evt_valid, 0);

    // backpressure with ch1 fall and rise pending
    evt_ready = 1'b0;
    sig_in = 4'b1101; step();
    sig_in = 4'b1111; step();
    for (int i = 0; i < 10; i++) begin
      step(); chk("bp_v", evt_valid, 1); chk("bp_c", evt_ch, 1);
    end
    evt_ready = 1'b1;
    clr_cnt();
    repeat (4) step();
    chk("bp_rise", cnt_rise[1], 1);
    chk("bp_fall", cnt_fall[1], 1);

    // overflow on ch0 while slot is blocked by ch3
    do_reset(4'b0000);
    evt_ready = 1'b0;
    sig_in = 4'b1000; step(); step();
    sig_in = 4'b1001; step();
    sig_in = 4'b1000; step();
    sig_in = 4'b1001; step();
    chk("ovf_set", ovf, 1);
    evt_ready = 1'b1;
    clr_cnt();
    repeat (6) step();
    chk("ovf_r0", cnt_rise[0], 1);
    chk("ovf_f0", cnt_fall[0], 1);
    chk("ovf_r3", cnt_rise[3], 1);
    chk("ovf_hold", ovf, 1);
    ovf_clr = 4'b0001; step(); ovf_clr = 4'b0000;
    chk("ovf_clr", ovf, 0);

    // ch2 rise granted in the same cycle a new ch2 rise is detected
    do_reset(4'b0000);
    evt_ready = 1'b0;
    sig_in = 4'b0001; step();
    sig_in = 4'b0101; step();
    sig_in = 4'b0001; step();
    sig_in = 4'b0101; evt_ready = 1'b1;
    clr_cnt();
    repeat (6) step();
    chk("col_r0", cnt_rise[0], 1);
    chk("col_r2", cnt_rise[2], 2);
    chk("col_f2", cnt_fall[2], 1);
    chk("col_ovf", ovf, 0);

    // reset mid-backpressure drops evt_valid at once
    evt_ready = 1'b0;
    sig_in = 4'b0000; step(); step();
    chk("mid_v", evt_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_async", evt_valid, 0);
    model_reset();
    step();
    reset = 1'b0;
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) sig_in[b] = ~sig_in[b];
        ovf_clr[b] = ($urandom_range(7) == 0);
      end
      evt_ready = ($urandom_range(2) != 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(499) == 0) reset = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
